instruction_encoder: RTL

Assembles RISC-V RV32I instructions from field-level requests (type, opcode, funct3/funct7, registers, immediate) and writes the 32-bit words sequentially into instruction memory. It is the inverse of the instruction decoder: the bit placement here is exactly the placement the decoder extracts. It sits between the program loader or self-test sequencer and the instruction-memory write port, with a small FIFO absorbing memory stalls.

---
 rtl/cpu_types.sv | 67 ++++++
 rtl/sync_fifo.sv | 54 +++++
 rtl/instruction_encoder.sv | 100 ++++++++++
 3 files changed

// File: rtl/cpu_types.sv
// Shared RV32I types: instruction format enum, major opcodes, and the
// field-to-word encoding used by the encoder and by decoder cross-checks.
package cpu_types;

  typedef enum logic [2:0] {
    INSTR_UNKNOWN = 3'd0,
    INSTR_R       = 3'd1,
    INSTR_I       = 3'd2,
    INSTR_S       = 3'd3,
    INSTR_SB      = 3'd4,
    INSTR_U       = 3'd5,
    INSTR_UJ      = 3'd6
  } instruction_type_type;

  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] JAL    = 7'h6F;
  localparam logic [6:0] JALR   = 7'h67;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] AUIPC  = 7'h17;

  typedef struct packed {
    instruction_type_type itype;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [31:0]          imm;
  } instr_req_t;

  // Bit placement mirrors what the decoder extracts; immediate bits outside
  // each format's field are dropped.
  function automatic logic [31:0] encode_instr(input instr_req_t r);
    logic [31:0] w;
    w = '0;
    case (r.itype)
      INSTR_R:  w = {r.funct7, r.rs2, r.rs1, r.funct3, r.rd, r.opcode};
      INSTR_I:  w = {r.imm[11:0], r.rs1, r.funct3, r.rd, r.opcode};
      INSTR_S:  w = {r.imm[11:5], r.rs2, r.rs1, r.funct3, r.imm[4:0], r.opcode};
      INSTR_SB: w = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.funct3,
                     r.imm[4:1], r.imm[11], r.opcode};
      INSTR_U:  w = {r.imm[31:12], r.rd, r.opcode};
      INSTR_UJ: w = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12],
                     r.rd, r.opcode};
      default:  w = '0;
    endcase
    return w;
  endfunction

  function automatic logic encode_reject(input instr_req_t r);
    logic bad;
    bad = 1'b0;
    case (r.itype)
      INSTR_R, INSTR_I, INSTR_S, INSTR_U: bad = 1'b0;
      INSTR_SB, INSTR_UJ:                 bad = r.imm[0];
      default:                            bad = 1'b1;
    endcase
    if (r.opcode[1:0] != 2'b11) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push into a full FIFO or pop from
// an empty one is ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = slots[rptr];

  always_ff @(posedge clk) begin
    if (do_push) slots[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/instruction_encoder.sv
// Encodes RV32I field requests into words and streams them, through a small
// FIFO, to sequential instruction-memory addresses starting at BASE_ADDR.
module instruction_encoder
  import cpu_types::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_type,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct3,
  input  logic [6:0]  req_funct7,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write,
  output logic        err,
  output logic        idle
);

  instr_req_t               req;
  logic                     accept;
  logic                     reject;
  logic                     enc_valid;
  logic                     enc_err;
  logic [31:0]              enc_word;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [31:0]              fifo_head;
  logic [$clog2(DEPTH):0]   fifo_count;

  always_comb begin
    req        = '0;
    req.itype  = instruction_type_type'(req_type);
    req.opcode = req_opcode;
    req.funct3 = req_funct3;
    req.funct7 = req_funct7;
    req.rd     = req_rd;
    req.rs1    = req_rs1;
    req.rs2    = req_rs2;
    req.imm    = req_imm;
  end

  assign reject = encode_reject(req);
  assign accept = req_valid && req_ready;

  // The encode stage counts against capacity so its push next cycle always fits.
  assign req_ready = (32'(fifo_count) + 32'(enc_valid)) < DEPTH;

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_valid <= 1'b0;
      enc_err   <= 1'b0;
      enc_word  <= '0;
    end else begin
      enc_valid <= accept && !reject;
      enc_err   <= accept && reject;
      enc_word  <= encode_instr(req);
    end
  end

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (enc_valid),
    .wdata (enc_word),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign fifo_pop  = !fifo_empty && mem_ready;
  assign mem_we    = !fifo_empty;
  assign mem_write = fifo_empty ? '0 : fifo_head;
  assign err       = enc_err;
  assign idle      = fifo_empty && !enc_valid;

  always_ff @(posedge clk) begin
    if (rst)           mem_address <= BASE_ADDR;
    else if (fifo_pop) mem_address <= mem_address + 32'd4;
  end

  a_ready_holds_space: assert property (@(posedge clk) disable iff (rst)
    enc_valid |-> !fifo_full || fifo_pop);

endmodule
